// File: rtl/recv_packet_ddr_if.sv
// rtl/recv_packet_ddr_if.sv - receive FIFO byte stream and DDR write port bundle
interface recv_packet_ddr_if;
  logic [7:0]   ff_rx_data;
  logic         ff_rx_sop;
  logic         ff_rx_eop;
  logic         ff_rx_err;
  logic         ff_rx_dval;
  logic         ff_rx_rdy;
  logic [24:0]  ram_address;
  logic [255:0] ram_data_write;
  logic         ram_wren;
  logic         ram_ready;

  modport master (
    output ff_rx_data, ff_rx_sop, ff_rx_eop, ff_rx_err, ff_rx_dval, ram_ready,
    input  ff_rx_rdy, ram_address, ram_data_write, ram_wren
  );

  modport slave (
    input  ff_rx_data, ff_rx_sop, ff_rx_eop, ff_rx_err, ff_rx_dval, ram_ready,
    output ff_rx_rdy, ram_address, ram_data_write, ram_wren
  );
endinterface

// File: rtl/recv_packet_ddr.sv
// rtl/recv_packet_ddr.sv - packs received bytes into 256-bit DDR words as a length-prefixed record
module recv_packet_ddr #(
  parameter int MAX_BYTES = 255
) (
  input  logic               clk_original,
  input  logic               rst,
  input  logic [24:0]        start_ram_addr,
  recv_packet_ddr_if.slave   bus,
  output logic               pkt_done,
  output logic               pkt_dropped,
  output logic [10:0]        pkt_len,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_WR_DATA, S_DISCARD, S_WR_LEN, S_DONE
  } state_t;

  localparam logic [10:0] MAX_CNT = 11'(MAX_BYTES);

  state_t        r_state;
  logic [24:0]   r_base;
  logic [10:0]   r_count;
  logic [255:0]  r_word;
  logic [5:0]    r_widx;
  logic          r_drop;
  logic          r_err;
  logic          r_ended;
  logic          r_rdy;
  logic          r_wren;
  logic [24:0]   r_addr;
  logic [255:0]  r_wdata;
  logic          r_done;
  logic          r_dropped;
  logic [10:0]   r_len;
  logic          r_busy;

  logic          w_take;
  logic          w_accept;
  logic [10:0]   w_count_inc;
  logic [255:0]  w_lane;
  logic [255:0]  w_merged;
  logic [24:0]   w_data_addr;
  logic [255:0]  w_len_word;

  assign w_take      = bus.ff_rx_dval & r_rdy;
  assign w_accept    = r_wren & bus.ram_ready;
  assign w_count_inc = r_count + 11'd1;
  // Byte 0 of a word lands in the top byte; later bytes walk down toward bit 0.
  assign w_lane      = {bus.ff_rx_data, 248'd0} >> {r_count[4:0], 3'b000};
  assign w_merged    = r_word | w_lane;
  assign w_data_addr = r_base + 25'd1 + {19'd0, r_widx};
  assign w_len_word  = (r_drop | r_err) ? 256'd0 : {245'd0, r_count};

  // r_rdy idles high; gating with rst keeps rdy low during reset yet high right after.
  assign bus.ff_rx_rdy      = r_rdy & ~rst;
  assign bus.ram_wren       = r_wren;
  assign bus.ram_address    = r_addr;
  assign bus.ram_data_write = r_wdata;
  assign pkt_done           = r_done;
  assign pkt_dropped        = r_dropped;
  assign pkt_len            = r_len;
  assign busy               = r_busy;

  always_ff @(posedge clk_original) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_count   <= '0;
      r_word    <= '0;
      r_widx    <= '0;
      r_drop    <= 1'b0;
      r_err     <= 1'b0;
      r_ended   <= 1'b0;
      r_rdy     <= 1'b1;
      r_wren    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_done    <= 1'b0;
      r_dropped <= 1'b0;
      r_len     <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_rdy  <= 1'b1;
          r_busy <= 1'b0;
          if (w_take && bus.ff_rx_sop) begin
            r_base  <= start_ram_addr;
            r_count <= 11'd1;
            r_word  <= {bus.ff_rx_data, 248'd0};
            r_widx  <= '0;
            r_drop  <= 1'b0;
            r_busy  <= 1'b1;
            r_ended <= bus.ff_rx_eop;
            r_err   <= bus.ff_rx_eop & bus.ff_rx_err;
            if (bus.ff_rx_eop) begin
              r_rdy   <= 1'b0;
              r_wren  <= 1'b1;
              r_addr  <= start_ram_addr + 25'd1;
              r_wdata <= {bus.ff_rx_data, 248'd0};
              r_state <= S_WR_DATA;
            end else begin
              r_state <= S_COLLECT;
            end
          end
        end

        S_COLLECT: begin
          if (w_take) begin
            if (bus.ff_rx_sop) begin
              r_drop <= 1'b1;
              if (bus.ff_rx_eop) begin
                r_rdy   <= 1'b0;
                r_wren  <= 1'b1;
                r_addr  <= r_base;
                r_wdata <= '0;
                r_state <= S_WR_LEN;
              end else begin
                r_state <= S_DISCARD;
              end
            end else if (r_count == MAX_CNT) begin
              // Overflow: flush any partial word, then swallow the rest of the packet.
              r_drop  <= 1'b1;
              r_ended <= bus.ff_rx_eop;
              if (r_count[4:0] != 5'd0) begin
                r_rdy   <= 1'b0;
                r_wren  <= 1'b1;
                r_addr  <= w_data_addr;
                r_wdata <= r_word;
                r_state <= S_WR_DATA;
              end else if (bus.ff_rx_eop) begin
                r_rdy   <= 1'b0;
                r_wren  <= 1'b1;
                r_addr  <= r_base;
                r_wdata <= '0;
                r_state <= S_WR_LEN;
              end else begin
                r_state <= S_DISCARD;
              end
            end else begin
              r_count <= w_count_inc;
              r_word  <= w_merged;
              if (bus.ff_rx_eop || w_count_inc[4:0] == 5'd0) begin
                r_rdy   <= 1'b0;
                r_wren  <= 1'b1;
                r_addr  <= w_data_addr;
                r_wdata <= w_merged;
                r_ended <= bus.ff_rx_eop;
                r_err   <= bus.ff_rx_eop & bus.ff_rx_err;
                r_state <= S_WR_DATA;
              end
            end
          end
        end

        S_WR_DATA: begin
          if (w_accept) begin
            r_word <= '0;
            r_widx <= r_widx + 6'd1;
            if (r_ended) begin
              r_addr  <= r_base;
              r_wdata <= w_len_word;
              r_state <= S_WR_LEN;
            end else begin
              r_wren  <= 1'b0;
              r_rdy   <= 1'b1;
              r_state <= r_drop ? S_DISCARD : S_COLLECT;
            end
          end
        end

        S_DISCARD: begin
          r_rdy <= 1'b1;
          if (w_take && bus.ff_rx_eop) begin
            r_rdy   <= 1'b0;
            r_wren  <= 1'b1;
            r_addr  <= r_base;
            r_wdata <= '0;
            r_state <= S_WR_LEN;
          end
        end

        S_WR_LEN: begin
          if (w_accept) begin
            r_wren    <= 1'b0;
            r_done    <= 1'b1;
            r_dropped <= r_drop | r_err;
            if (!(r_drop | r_err)) begin
              r_len <= r_count;
            end
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          r_dropped <= 1'b0;
          r_drop    <= 1'b0;
          r_err     <= 1'b0;
          r_ended   <= 1'b0;
          r_word    <= '0;
          r_rdy     <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end

        default: begin
          r_rdy   <= 1'b1;
          r_wren  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
